// File: rtl/hs_link_pkg.sv
// Shared types and sizing helpers for the send/ack link arbiter.
package hs_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_HI,
    WAIT_LO,
    DONE,
    ERR
  } state_t;

  // Width of a requester index / round-robin pointer.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of the ack-edge timer: must hold the value TIMEOUT itself.
  function automatic int timer_w(input int t);
    return (t > 0) ? $clog2(t + 1) : 1;
  endfunction

endpackage

// File: rtl/hs_link_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
  import hs_link_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  // Scan from farthest to nearest so the candidate closest to ptr wins.
  always_comb begin
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % N_REQ]) begin
        gnt_idx = IDX_W'((int'(ptr) + k) % N_REQ);
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_link_arbiter.sv
// Round-robin arbiter sharing one 4-phase send/ack link between N_REQ requesters,
// with per-edge timeout and done/err pulses back to the served requester.
module hs_link_arbiter
  import hs_link_pkg::*;
#(
  parameter  int N_REQ       = 4,
  parameter  int DATA_W      = 4,
  parameter  int TIMEOUT     = 255,
  parameter  int SYNC_STAGES = 2,
  localparam int IDX_W       = idx_w(N_REQ),
  localparam int TIMER_W     = timer_w(TIMEOUT)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        req_err,
  output logic                    link_send,
  output logic [DATA_W-1:0]       link_data,
  input  logic                    link_ack,
  output logic                    busy,
  output logic [IDX_W-1:0]        grant_id
);

  state_t             state, state_d;
  logic [TIMER_W-1:0] timer;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   ptr_nxt;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  logic [N_REQ-1:0]   req_eff;
  logic               ack_s;
  logic               timer_hit;

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign ack_s = link_ack;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] ack_q;
      // Preset to "ack high" so a reset mid-handshake cannot grant on a stale
      // synchronizer value before the real ack has been observed low.
      always_ff @(posedge clk) begin
        if (!rst) ack_q <= '1;
        else      ack_q <= SYNC_STAGES'({ack_q, link_ack});
      end
      assign ack_s = ack_q[SYNC_STAGES-1];
    end
  endgenerate

  // A requester whose done/err pulse is out this cycle has not yet dropped its
  // valid; hide it so it is not granted a second time.
  assign req_eff   = req_valid & ~(req_done | req_err);
  assign timer_hit = (timer == TIMER_W'(TIMEOUT));
  assign ptr_nxt   = (grant_id == IDX_W'(N_REQ - 1)) ? '0 : grant_id + IDX_W'(1);

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req    (req_eff),
    .ptr    (ptr),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (pick_any && !ack_s) state_d = WAIT_HI;
      WAIT_HI: if (ack_s)              state_d = WAIT_LO;
               else if (timer_hit)     state_d = ERR;
      WAIT_LO: if (!ack_s)             state_d = DONE;
               else if (timer_hit)     state_d = ERR;
      DONE:                            state_d = IDLE;
      ERR:                             state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      timer     <= '0;
      ptr       <= '0;
      grant_id  <= '0;
      link_data <= '0;
      link_send <= 1'b0;
      busy      <= 1'b0;
      req_done  <= '0;
      req_err   <= '0;
    end else begin
      state     <= state_d;
      busy      <= (state_d != IDLE);
      // Send rises one cycle after the grant and falls on ack or timeout.
      link_send <= (state == WAIT_HI) && (state_d == WAIT_HI);
      req_done  <= '0;
      req_err   <= '0;

      if (state_d != state)
        timer <= '0;
      else if (state == WAIT_HI || state == WAIT_LO)
        timer <= timer + TIMER_W'(1);

      if (state == IDLE && state_d == WAIT_HI) begin
        grant_id  <= pick_idx;
        link_data <= req_data[int'(pick_idx)*DATA_W +: DATA_W];
      end

      if (state == DONE) begin
        req_done[grant_id] <= 1'b1;
        ptr                <= ptr_nxt;
      end

      if (state == ERR) begin
        req_err[grant_id] <= 1'b1;
        ptr               <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_hs_link_arbiter.sv
// Directed bench for hs_link_arbiter with a simple delayed-echo peripheral model.
module tb_hs_link_arbiter;

  localparam int N_REQ       = 4;
  localparam int DATA_W      = 4;
  localparam int TIMEOUT     = 255;
  localparam int SYNC_STAGES = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [3:0]  req_done;
  logic [3:0]  req_err;
  logic        link_send;
  logic [3:0]  link_data;
  logic        link_ack;
  logic        busy;
  logic [1:0]  grant_id;

  // Peripheral: 0 = ack follows send delayed 2 cycles, 1 = never acks, 2 = manual
  int   per_mode = 0;
  logic man_ack = 1'b0;
  logic d1 = 1'b0;
  logic d2 = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    d1 <= link_send;
    d2 <= d1;
  end

  assign link_ack = (per_mode == 0) ? d2 : ((per_mode == 2) ? man_ack : 1'b0);

  hs_link_arbiter #(
    .N_REQ(N_REQ), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_done(req_done), .req_err(req_err), .link_send(link_send),
    .link_data(link_data), .link_ack(link_ack), .busy(busy), .grant_id(grant_id)
  );

  // Runs until the first done/err pulse; reports what was granted and observed.
  task automatic run_xfer(input int budget, input bit drop,
                          output int gid, output logic [3:0] ld,
                          output logic [3:0] dn, output logic [3:0] er,
                          output int send_cyc, output logic bsy_fin,
                          output logic snd_fin, output bit ok);
    bit got_busy = 1'b0;
    gid = -1; ld = '0; dn = '0; er = '0; send_cyc = 0;
    bsy_fin = 1'b1; snd_fin = 1'b1; ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (busy && !got_busy) begin
        got_busy = 1'b1;
        gid = int'(grant_id);
        ld  = link_data;
      end
      if (link_send) send_cyc++;
      if ((req_done | req_err) != 4'b0000) begin
        dn = req_done; er = req_err;
        bsy_fin = busy; snd_fin = link_send; ok = 1'b1;
        if (drop) req_valid = req_valid & ~(req_done | req_err);
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    int gid; logic [3:0] ld, dn, er; int sc; logic bf, sf; bit ok;
    rst = 1'b0; req_valid = 4'b1111; req_data = 16'hDCBA;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (link_send !== 1'b0) begin n_fail++; $display("FAIL reset_send cyc %0d: got %b want 0", c, link_send); end
    end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (req_done !== 4'h0)  begin n_fail++; $display("FAIL reset_done: got %b want 0000", req_done); end
    n_checks++; if (req_err !== 4'h0)   begin n_fail++; $display("FAIL reset_err: got %b want 0000", req_err); end
    n_checks++; if (link_data !== 4'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", link_data); end
    n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL reset_gid: got %0d want 0", grant_id); end
    rst = 1'b1;
    run_xfer(60, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
    req_valid = 4'b0000;
    n_checks++; if (!ok)           begin n_fail++; $display("FAIL reset_first_xfer: no completion within budget"); end
    n_checks++; if (gid != 0)      begin n_fail++; $display("FAIL reset_first_gid: got %0d want 0", gid); end
    n_checks++; if (dn !== 4'b0001) begin n_fail++; $display("FAIL reset_first_done: got %b want 0001", dn); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int gid; logic [3:0] ld, dn, er; int sc; logic bf, sf; bit ok;
    req_data = 16'h5A31; req_valid = 4'b0100;
    run_xfer(60, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
    n_checks++; if (!ok)            begin n_fail++; $display("FAIL single_xfer: no completion within budget"); end
    n_checks++; if (gid != 2)       begin n_fail++; $display("FAIL single_gid: got %0d want 2", gid); end
    n_checks++; if (ld !== 4'hA)    begin n_fail++; $display("FAIL single_data: got %h want a", ld); end
    n_checks++; if (dn !== 4'b0100) begin n_fail++; $display("FAIL single_done: got %b want 0100", dn); end
    n_checks++; if (er !== 4'b0000) begin n_fail++; $display("FAIL single_err: got %b want 0000", er); end
    n_checks++; if (sc != 5)        begin n_fail++; $display("FAIL single_send_len: got %0d want 5", sc); end
    n_checks++; if (bf !== 1'b0)    begin n_fail++; $display("FAIL single_busy_at_done: got %b want 0", bf); end
    @(negedge clk);
    n_checks++; if (req_done !== 4'h0)  begin n_fail++; $display("FAIL single_pulse_len: got %b want 0000", req_done); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL single_busy_after: got %b want 0", busy); end
    n_checks++; if (link_data !== 4'hA) begin n_fail++; $display("FAIL single_data_hold: got %h want a", link_data); end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_fairness();
    int exp_id[6] = '{0, 1, 2, 3, 0, 1};
    int gid; logic [3:0] ld, dn, er; int sc; logic bf, sf; bit ok;
    int prev = -1;
    logic [3:0] exp_ld, exp_dn;
    do_reset();
    req_data = 16'hDCBA; req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      run_xfer(60, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
      req_valid = 4'b1111;
      exp_ld = 4'hA + 4'(exp_id[k]);
      exp_dn = 4'(1 << exp_id[k]);
      n_checks++; if (!ok || gid != exp_id[k]) begin n_fail++; $display("FAIL fair_gid[%0d]: got %0d want %0d", k, gid, exp_id[k]); end
      n_checks++; if (ld !== exp_ld)  begin n_fail++; $display("FAIL fair_data[%0d]: got %h want %h", k, ld, exp_ld); end
      n_checks++; if (dn !== exp_dn)  begin n_fail++; $display("FAIL fair_done[%0d]: got %b want %b", k, dn, exp_dn); end
      n_checks++; if (gid == prev)    begin n_fail++; $display("FAIL fair_repeat[%0d]: id %0d served twice in a row (want a different id)", k, gid); end
      prev = gid;
    end
    req_valid = 4'b0000;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_timeout();
    int gid; logic [3:0] ld, dn, er; int sc; logic bf, sf; bit ok;
    do_reset();
    per_mode = 1; req_data = 16'h5A31; req_valid = 4'b0100;
    run_xfer(400, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
    n_checks++; if (!ok)            begin n_fail++; $display("FAIL tmo_xfer: no err within budget"); end
    n_checks++; if (gid != 2)       begin n_fail++; $display("FAIL tmo_gid: got %0d want 2", gid); end
    n_checks++; if (er !== 4'b0100) begin n_fail++; $display("FAIL tmo_err: got %b want 0100", er); end
    n_checks++; if (dn !== 4'b0000) begin n_fail++; $display("FAIL tmo_done: got %b want 0000", dn); end
    n_checks++; if (sc != TIMEOUT)  begin n_fail++; $display("FAIL tmo_send_len: got %0d want %0d", sc, TIMEOUT); end
    n_checks++; if (sf !== 1'b0)    begin n_fail++; $display("FAIL tmo_send_at_err: got %b want 0", sf); end
    // Pointer now at 3: with 0 and 3 pending, 3 must win.
    per_mode = 0; req_valid = 4'b1001;
    run_xfer(60, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
    req_valid = 4'b0000;
    n_checks++; if (!ok || gid != 3) begin n_fail++; $display("FAIL tmo_ptr_adv: got id %0d want 3", gid); end
    n_checks++; if (dn !== 4'b1000)  begin n_fail++; $display("FAIL tmo_next_done: got %b want 1000", dn); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_stale_ack();
    int gid; logic [3:0] ld, dn, er; int sc; logic bf, sf; bit ok;
    bit seen = 1'b0;
    per_mode = 2; man_ack = 1'b1;
    repeat (4) @(negedge clk);
    req_data = 16'h5A31; req_valid = 4'b0001;
    repeat (8) begin
      @(negedge clk);
      if (busy || link_send) seen = 1'b1;
    end
    n_checks++; if (seen) begin n_fail++; $display("FAIL stale_grant: got a grant while ack high, want none"); end
    man_ack = 1'b0; per_mode = 0;
    run_xfer(60, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
    req_valid = 4'b0000;
    n_checks++; if (!ok || gid != 0) begin n_fail++; $display("FAIL stale_gid: got %0d want 0", gid); end
    n_checks++; if (ld !== 4'h1)     begin n_fail++; $display("FAIL stale_data: got %h want 1", ld); end
    n_checks++; if (dn !== 4'b0001)  begin n_fail++; $display("FAIL stale_done: got %b want 0001", dn); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_midop_reset();
    int gid; logic [3:0] ld, dn, er; int sc; logic bf, sf; bit ok;
    bit sent = 1'b0;
    bit reached = 1'b0;
    per_mode = 0; req_data = 16'h5A31; req_valid = 4'b0010;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (link_send) sent = 1'b1;
      if (sent && !link_send && busy) begin reached = 1'b1; break; end
    end
    n_checks++; if (!reached) begin n_fail++; $display("FAIL midrst_reach_wait_lo: state not reached within budget"); end
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (link_send !== 1'b0) begin n_fail++; $display("FAIL midrst_send: got %b want 0", link_send); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_checks++; if ((req_done | req_err) !== 4'h0) begin n_fail++; $display("FAIL midrst_pulse: got done %b err %b want 0", req_done, req_err); end
    n_checks++; if (grant_id !== 2'd0)  begin n_fail++; $display("FAIL midrst_gid: got %0d want 0", grant_id); end
    rst = 1'b1;
    run_xfer(80, 1'b1, gid, ld, dn, er, sc, bf, sf, ok);
    req_valid = 4'b0000;
    n_checks++; if (!ok || gid != 1) begin n_fail++; $display("FAIL midrst_gid_after: got %0d want 1", gid); end
    n_checks++; if (ld !== 4'h3)     begin n_fail++; $display("FAIL midrst_data: got %h want 3", ld); end
    n_checks++; if (dn !== 4'b0010 || er !== 4'b0000) begin n_fail++; $display("FAIL midrst_done: got done %b err %b want 0010/0000", dn, er); end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_stale_ack();
    test_midop_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got no end want end");
    $fatal(1, "watchdog");
  end

endmodule
